serial_parity_rx: RTL and testbench
===================================

// Module: serial_parity_rx
// PURPOSE
//  Serial frame receiver/checker: accepts bits one per valid cycle, MSB first: DATA_W data bits, then 1 parity bit.
//  Accumulates running XOR parity over the data bits, compares it with the received parity bit,
//  and presents the deserialized word plus an error flag.
//  Sits directly downstream of the combinational XOR/parity generator stage; consumes the serial stream that stage protects.
// PARAMETERS
//  DATA_W   8   data bits per frame (>=2); frame length = DATA_W+1 bits
//  ODD      0   0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = ~XOR of data)
// PORTS
//  clk         in   1        rising-edge clock, single clock domain
//  rst         in   1        asynchronous, active-high reset
//  clr         in   1        synchronous abort: discard partial frame, return to IDLE
//  in_valid    in   1        in_bit is valid this cycle
//  in_bit      in   1        serial bit, MSB of data first, parity bit last
//  busy        out  1        frame in progress (state != IDLE)
//  out_valid   out  1        1-cycle pulse: frame complete, out_data/parity_err updated
//  out_data    out  DATA_W   last completed data word, held until the next frame completes
//  parity_err  out  1        1 = received parity mismatched computed parity; held with out_data
// BEHAVIOUR
//  Reset (async, rst=1): state=IDLE, bit counter=0, shift reg=0, running parity=0;
//   busy=0, out_valid=0, out_data=0, parity_err=0. Outputs are registered; no comb path from in_* to outputs.
//  FSM states: IDLE, DATA, PAR.
//   IDLE: in_valid=1 -> shift in_bit, parity<=in_bit, cnt<=1, go DATA (cnt=1 already counts the first bit).
//   DATA: each in_valid -> shift left, insert in_bit at LSB, parity<=parity^in_bit, cnt<=cnt+1.
//         When the accepted bit is data bit DATA_W (cnt==DATA_W-1 before the edge), go PAR.
//   PAR:  in_valid -> out_data<=shift reg; parity_err<=(in_bit != (parity ^ ODD));
//         out_valid<=1 for exactly one cycle; go IDLE; cnt and parity clear to 0.
//  in_valid=0 in any state: hold everything (stall, no timeout); out_valid deasserts after its single cycle.
//  Latency: out_valid is high in the cycle after the edge that accepts the parity bit.
//  Back-to-back frames: the first bit of the next frame is accepted in the same cycle out_valid is high
//   (IDLE accepts immediately), so frames run with no gap.
//  Counter width: $clog2(DATA_W+1); never exceeds DATA_W; no wrap-around.
//  clr=1: state<=IDLE, cnt/parity/shift reg cleared; in_bit in that cycle is ignored.
//   out_data/parity_err keep last completed values; out_valid=0. clr has priority over in_valid.
//  clr in PAR state: the frame is dropped; no out_valid is produced.
//  rst mid-frame: immediate return to reset values; the partial frame is lost.
// STRUCTURE
//  Shared header parity_defs.vh: state encodings ST_IDLE=2'd0, ST_DATA=2'd1, ST_PAR=2'd2; default DATA_W.
//  One sub-module is natural: the running-parity update reuses the existing 2-input xor_gate (a,b,y),
//   with a=parity_q, b=in_bit, y=parity_next.
//  The rest is inline: FSM, counter, shift reg, output regs.
// TESTING (DATA_W=8, ODD=0 unless noted)
//  1 rst=1 mid-stream then release -> all outputs 0, busy=0; no out_valid until 9 bits have been accepted.
//  2 Stream 8'hA5 (parity 0) then 0, contiguous -> out_valid=1 for one cycle, 1 cycle after the 9th bit;
//    out_data=8'hA5, parity_err=0.
//  3 Stream 8'h01 with parity bit 0 -> out_data=8'h01, parity_err=1.
//    Same frame with ODD=1 and parity bit 0 -> parity_err=0.
//  4 8'h3C frame with random in_valid gaps (1-3 cycles) -> same result as contiguous;
//    busy stays 1 through the gaps; exactly one out_valid.
//  5 Back-to-back frames 8'hFF/par 0 then 8'h80/par 1 -> two out_valid pulses 9 cycles apart,
//    both with parity_err=0; out_data 8'hFF then 8'h80.
//  6 clr after 5 bits, then a full 8'h5A/par 0 frame -> only one out_valid, out_data=8'h5A;
//    rst asserted during PAR -> no out_valid, outputs 0.

Source files
------------

// File: rtl/serial_parity_rx_pkg.sv
// Shared definitions for the serial parity receiver.
//   state_t        : FSM state encoding (IDLE, DATA, PAR)
//   DEFAULT_DATA_W : default number of data bits per frame
package serial_parity_rx_pkg;

    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_parity_rx_xor_gate.sv
// Two-input XOR gate used for the running-parity update.
//   a : current running parity
//   b : incoming serial bit
//   y : a ^ b
module serial_parity_rx_xor_gate (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = a ^ b;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial frame receiver/checker. Bits arrive MSB first, one per in_valid
// cycle: DATA_W data bits followed by one parity bit. The running XOR of the
// data bits is compared against the received parity bit, and the
// deserialized word is presented together with an error flag.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   clr        : synchronous abort, drops any partial frame (beats in_valid)
//   in_valid   : in_bit is valid this cycle
//   in_bit     : serial data, MSB first, parity bit last
//   busy       : a frame is in progress
//   out_valid  : one-cycle pulse, out_data/parity_err just updated
//   out_data   : last completed data word (held)
//   parity_err : parity mismatch flag for out_data (held)
module serial_parity_rx
    import serial_parity_rx_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic              in_bit,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              parity_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                parity_q, parity_d;
    logic                parity_next;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                parity_err_q, parity_err_d;

    serial_parity_rx_xor_gate u_xor (
        .a (parity_q),
        .b (in_bit),
        .y (parity_next)
    );

    always_comb begin
        // NOTE: every signal gets a hold/default value before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        parity_err_d = parity_err_q;

        if (clr) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            shift_d  = '0;
            parity_d = 1'b0;
        end else if (in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    // First data bit: parity restarts from this bit alone.
                    shift_d  = {shift_q[DATA_W-2:0], in_bit};
                    parity_d = in_bit;
                    cnt_d    = CNT_W'(1);
                    state_d  = ST_DATA;
                end
                ST_DATA: begin
                    shift_d  = {shift_q[DATA_W-2:0], in_bit};
                    parity_d = parity_next;
                    cnt_d    = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = ST_PAR;
                    end
                end
                ST_PAR: begin
                    out_data_d   = shift_q;
                    parity_err_d = (in_bit != (parity_q ^ ODD));
                    out_valid_d  = 1'b1;
                    cnt_d        = '0;
                    parity_d     = 1'b0;
                    state_d      = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_serial_parity_rx.sv
// Self-checking bench for serial_parity_rx. Two instances share the stimulus:
// one with even parity, one with odd parity. A bit-queue reference model
// predicts every output in every cycle.
module tb_serial_parity_rx;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_bit = 1'b0;

    logic              busy, out_valid, parity_err;
    logic [DATA_W-1:0] out_data;
    logic              busy_o, out_valid_o, parity_err_o;
    logic [DATA_W-1:0] out_data_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic              bits_q[$];
    logic [DATA_W-1:0] exp_data = '0;
    logic              exp_err = 1'b0;
    logic              exp_err_odd = 1'b0;
    logic              exp_valid = 1'b0;
    int                cyc = 0;
    int                pulses[$];

    always #5 clk = ~clk;

    serial_parity_rx #(.DATA_W(DATA_W), .ODD(1'b0)) u_dut_even (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .parity_err (parity_err)
    );

    serial_parity_rx #(.DATA_W(DATA_W), .ODD(1'b1)) u_dut_odd (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .busy       (busy_o),
        .out_valid  (out_valid_o),
        .out_data   (out_data_o),
        .parity_err (parity_err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic check_all(input string tag);
        check({tag, ".valid"},   32'(out_valid),    32'(exp_valid));
        check({tag, ".busy"},    32'(busy),         32'(bits_q.size() != 0));
        check({tag, ".data"},    32'(out_data),     32'(exp_data));
        check({tag, ".err"},     32'(parity_err),   32'(exp_err));
        check({tag, ".valid_o"}, 32'(out_valid_o),  32'(exp_valid));
        check({tag, ".busy_o"},  32'(busy_o),       32'(bits_q.size() != 0));
        check({tag, ".data_o"},  32'(out_data_o),   32'(exp_data));
        check({tag, ".err_o"},   32'(parity_err_o), 32'(exp_err_odd));
    endtask

    // One clock cycle: drive inputs, let the edge happen, update the model, check.
    task automatic cycle(input logic v, input logic b, input logic c, input string tag);
        logic [DATA_W-1:0] word;
        logic              par;
        in_valid = v;
        in_bit   = b;
        clr      = c;
        @(posedge clk);
        #1;
        cyc++;
        exp_valid = 1'b0;
        if (c) begin
            bits_q.delete();
        end else if (v) begin
            bits_q.push_back(b);
            if (bits_q.size() == DATA_W + 1) begin
                for (int i = 0; i < DATA_W; i++) word[DATA_W-1-i] = bits_q[i];
                par         = bits_q[DATA_W];
                exp_data    = word;
                exp_err     = (par != (^word));
                exp_err_odd = (par != ~(^word));
                exp_valid   = 1'b1;
                bits_q.delete();
            end
        end
        if (out_valid) pulses.push_back(cyc);
        check_all(tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 1'b0, tag);
    endtask

    // Send a frame MSB first, then the parity bit; optional random stalls.
    task automatic send_frame(input logic [DATA_W-1:0] data, input logic par,
                              input bit gaps, input string tag);
        logic [DATA_W:0] frame;
        frame = {data, par};
        for (int i = DATA_W; i >= 0; i--) begin
            if (gaps) idle_cycles(int'($urandom_range(1, 3)), tag);
            cycle(1'b1, frame[i], 1'b0, tag);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        rst      = 1'b1;
        #2;
        bits_q.delete();
        exp_data    = '0;
        exp_err     = 1'b0;
        exp_err_odd = 1'b0;
        exp_valid   = 1'b0;
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Test 1: reset, then reset again mid-stream.
        do_reset("rst0");
        idle_cycles(2, "idle");
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom), 1'b0, "pre_rst");
        do_reset("rst_mid");
        idle_cycles(1, "post_rst");

        // Test 2: 0xA5, even parity bit 0, contiguous.
        pulses.delete();
        send_frame(8'hA5, 1'b0, 1'b0, "a5");
        check("a5.pulse_cnt", 32'(pulses.size()), 32'd1);
        check("a5.data", 32'(out_data), 32'hA5);
        check("a5.err", 32'(parity_err), 32'd0);
        idle_cycles(2, "a5_hold");

        // Test 3: 0x01 with parity bit 0 -> even err, odd ok.
        send_frame(8'h01, 1'b0, 1'b0, "x01");
        check("x01.err_even", 32'(parity_err), 32'd1);
        check("x01.err_odd", 32'(parity_err_o), 32'd0);
        idle_cycles(1, "x01_hold");

        // Test 4: 0x3C with random stalls -> exactly one pulse.
        pulses.delete();
        send_frame(8'h3C, 1'b0, 1'b1, "x3c");
        idle_cycles(3, "x3c_hold");
        check("x3c.pulse_cnt", 32'(pulses.size()), 32'd1);
        check("x3c.data", 32'(out_data), 32'h3C);

        // Test 5: back-to-back 0xFF/0 and 0x80/1, pulses 9 cycles apart.
        pulses.delete();
        send_frame(8'hFF, 1'b0, 1'b0, "xff");
        send_frame(8'h80, 1'b1, 1'b0, "x80");
        idle_cycles(2, "b2b_hold");
        check("b2b.pulse_cnt", 32'(pulses.size()), 32'd2);
        if (pulses.size() == 2)
            check("b2b.spacing", 32'(pulses[1] - pulses[0]), 32'd9);
        check("b2b.data", 32'(out_data), 32'h80);

        // Test 6a: clr after 5 bits, then full 0x5A frame.
        pulses.delete();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom), 1'b0, "pre_clr");
        cycle(1'b1, 1'b1, 1'b1, "clr");
        send_frame(8'h5A, 1'b0, 1'b0, "x5a");
        idle_cycles(2, "x5a_hold");
        check("x5a.pulse_cnt", 32'(pulses.size()), 32'd1);
        check("x5a.data", 32'(out_data), 32'h5A);

        // Test 6b: clr while waiting for the parity bit drops the frame.
        pulses.delete();
        for (int i = 0; i < DATA_W; i++) cycle(1'b1, 1'($urandom), 1'b0, "pre_par_clr");
        cycle(1'b1, 1'b0, 1'b1, "par_clr");
        idle_cycles(2, "par_clr_hold");
        check("par_clr.pulse_cnt", 32'(pulses.size()), 32'd0);

        // Test 6c: rst while waiting for the parity bit.
        pulses.delete();
        for (int i = 0; i < DATA_W; i++) cycle(1'b1, 1'($urandom), 1'b0, "pre_par_rst");
        do_reset("par_rst");
        idle_cycles(2, "par_rst_hold");
        check("par_rst.pulse_cnt", 32'(pulses.size()), 32'd0);

        // Random traffic: random data/parity, stalls and occasional clr.
        for (int f = 0; f < 60; f++) begin
            for (int i = 0; i < 12; i++) begin
                if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), "rnd_gap");
                if ($urandom_range(0, 40) == 0)
                    cycle(1'($urandom), 1'($urandom), 1'b1, "rnd_clr");
                else
                    cycle(1'b1, 1'($urandom), 1'b0, "rnd");
            end
        end
        idle_cycles(3, "end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
